// File: rtl/ham_pkg.sv
// Shared types for the Hamming (7,4) transmit path.
package ham_pkg;

    localparam int HAM_DATA_W = 4;
    localparam int HAM_CODE_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } ham_tx_state_e;

    typedef logic [HAM_CODE_W-1:0] ham_code_t;

endpackage

// File: rtl/ham_encoder.sv
// Combinational Hamming (7,4) encoder; codeword layout {d3,d2,d1,p2,d0,p1,p0}.
module ham_encoder
    import ham_pkg::*;
(
    input  logic [HAM_DATA_W-1:0] i_data,
    output ham_code_t             o_code
);

    logic w_p0;
    logic w_p1;
    logic w_p2;

    assign w_p0 = i_data[0] ^ i_data[1] ^ i_data[3];
    assign w_p1 = i_data[0] ^ i_data[2] ^ i_data[3];
    assign w_p2 = i_data[1] ^ i_data[2] ^ i_data[3];

    assign o_code = {i_data[3], i_data[2], i_data[1], w_p2, i_data[0], w_p1, w_p0};

endmodule

// File: rtl/ham_tx_scheduler.sv
// Round-robin byte scheduler feeding one shared Hamming encoder, low nibble first.
//   state   | meaning
//   IDLE    | no byte held
//   SEND_LO | presenting low-nibble codeword
//   SEND_HI | presenting high-nibble codeword
module ham_tx_scheduler
    import ham_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 code_valid,
    input  logic                 code_ready,
    output ham_code_t            code,
    output logic [SRC_W-1:0]     code_src,
    output logic                 code_last,
    output logic                 busy
);

    localparam int IDX_W = SRC_W + 1;

    ham_tx_state_e          r_state;
    ham_tx_state_e          w_state_nxt;
    logic [SRC_W-1:0]       r_ptr;
    logic [SRC_W-1:0]       r_src;
    logic [7:0]             r_byte;

    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [NUM_REQ-1:0]     w_rot;
    logic                   w_found;
    logic [SRC_W-1:0]       w_grant;
    logic [IDX_W-1:0]       w_sum;
    logic                   w_window;
    logic                   w_take;
    logic [HAM_DATA_W-1:0]  w_nib;

    // Rotate the doubled request vector so bit 0 is rr_ptr; first set bit wins.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NUM_REQ'(w_dbl >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + IDX_W'(i);
                if (w_sum >= IDX_W'(NUM_REQ)) begin
                    w_sum = w_sum - IDX_W'(NUM_REQ);
                end
                w_grant = SRC_W'(w_sum);
            end
        end
    end

    assign w_window  = (r_state == IDLE) || ((r_state == SEND_HI) && code_ready);
    assign w_take    = w_window && w_found && !reset;
    assign req_ready = w_take ? (NUM_REQ'(1) << w_grant) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_nxt = SEND_LO;
            SEND_LO: if (code_ready) w_state_nxt = SEND_HI;
            SEND_HI: if (code_ready) w_state_nxt = w_take ? SEND_LO : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_src   <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_byte <= 8'(req_data >> {w_grant, 3'b000});
                r_src  <= w_grant;
                r_ptr  <= (w_grant == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    assign w_nib = (r_state == SEND_HI) ? r_byte[7:4] : r_byte[3:0];

    ham_encoder u_enc (
        .i_data (w_nib),
        .o_code (code)
    );

    assign code_valid = (r_state != IDLE);
    assign busy       = (r_state != IDLE);
    assign code_last  = (r_state == SEND_HI);
    assign code_src   = r_src;

endmodule
